mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU memory bus, downstream of the cpu block.
- Decodes the CPU's address, to_memory and write outputs. Supplies a registered read byte plus a hit flag, which the memory output mux uses to drive from_memory.
- Buffers outgoing bytes in a small FIFO and serialises them 8N1 on a single tx line.

Parameters:
- BASE_ADDR, 8'hE0, base of the 3-byte register window (BASE..BASE+2).
- CLKS_PER_BIT, 16, clock cycles per serial bit. Minimum 2.
- FIFO_DEPTH, 4, FIFO entries. Power of 2, 2..16.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  8  CPU bus address.
- to_memory  in  8  CPU write data.
- write  in  1  CPU write strobe; active-high, sampled at the edge.
- data_out  out  8  registered read data for the addressed register.
- hit  out  1  registered; 1 when the previous-cycle address was in the window.
- tx  out  1  serial output; idles at 1.
- busy  out  1  1 while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Reset (sync, active-high): FIFO emptied (count=0, pointers=0), overflow=0, FSM=IDLE, tx=1, busy=0, data_out=8'h00, hit=0. Reset mid-frame aborts the frame; tx=1 after that edge.
- Register map, offset from BASE_ADDR:
  - +0 TX_DATA. Write pushes to_memory into the FIFO. Read returns 8'h00.
  - +1 STATUS. Read returns {4'b0, overflow, empty, full, busy}. A write with to_memory[3]=1 clears overflow; other bits are ignored.
  - +2 COUNT. Read returns the FIFO occupancy, zero-extended. Writes are ignored.
  - Addresses outside BASE..BASE+2: no effect; hit=0 next cycle, data_out=8'h00.
- Read latency is 1 cycle: data_out and hit reflect the address presented at the previous edge. Status and count are sampled before that edge's updates.
- Push/pop: write to TX_DATA is a push.
  - Push when not full: accepted.
  - Push when full with no simultaneous pop: data dropped, overflow set (sticky).
  - Push when full with a simultaneous pop: accepted, count unchanged.
  - Overflow set and clear in the same cycle: set wins.
  - Pointers wrap modulo FIFO_DEPTH. The count register is wide enough to hold FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at the edge, pop the head into the shift register, clear the bit counter, go to START. A push into an empty FIFO pops on the following edge, never the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If the FIFO is non-empty at the final edge, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is registered (glitch-free).
- The baud counter runs 0..CLKS_PER_BIT-1 and resets on every state change.
- busy = (state != IDLE) or (count != 0).
- Latency: a write at edge N lands in the FIFO. Pop happens at edge N+1, and tx falls after edge N+1.

Test Plan:
- Reset: assert reset 2 cycles mid-frame (CLKS_PER_BIT=4) -> next cycle tx=1, busy=0, STATUS read returns 8'h04 (empty=1), COUNT=0.
- Single byte: CLKS_PER_BIT=4, write 8'hA5 to 8'hE0 at edge N -> tx low from N+1 for 4 cycles. Then data bits 1,0,1,0,0,1,0,1, 4 cycles each. Then stop=1 for 4 cycles. Total 40 cycles. busy drops after the stop bit.
- Back-to-back: write 8'h01, 8'h80, 8'hFF on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between them. COUNT read right after the third write returns 8'h02.
- Overflow: FIFO_DEPTH=4, tx busy. Write 6 bytes rapidly -> 1 is shifting, 4 are queued, the 6th is dropped. STATUS reads 8'h0B (overflow, full, busy). Writing 8'h08 to 8'hE1 -> STATUS reads 8'h03. Only 5 frames are transmitted.
- Full with simultaneous pop: FIFO full, push on the STOP-to-START pop edge -> push accepted, COUNT stays 4, overflow stays 0.
- Decode: read 8'hE3 and 8'hDF -> hit=0, data_out=8'h00. A write to 8'hE2 changes nothing. A read of 8'hE0 returns 8'h00 with hit=1 one cycle later.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Register window (offset from BASE_ADDR):
//   +0 TX_DATA  write: push to_memory into the FIFO      read: 8'h00
//   +1 STATUS   read: {4'b0, overflow, empty, full, busy}
//               write: to_memory[3]=1 clears overflow
//   +2 COUNT    read: FIFO occupancy, zero-extended       write: ignored
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   address    CPU bus address
//   to_memory  CPU write data
//   write      CPU write strobe, sampled at the edge
//   data_out   registered read data for the address of the previous edge
//   hit        registered; 1 when the previous-edge address was in the window
//   tx         registered serial output, idles high
//   busy       1 while a frame is shifting or the FIFO holds data
//   state_dbg  current TX FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: the bus side has no back-pressure. A write strobe is a
// one-cycle valid with an implied ready of 1; a push into a full FIFO
// with no simultaneous pop is dropped and flagged in the sticky overflow.

module mmio_uart_tx #(
  parameter logic [7:0] BASE_ADDR    = 8'hE0,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] to_memory,
  input  logic       write,
  output logic [7:0] data_out,
  output logic       hit,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;
  logic          pop;
  logic          baud_last;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [7:0]    offset;
  logic          in_window;
  logic          push, push_ok, ovf_set, ovf_clr;
  logic          full, empty;
  logic [7:0]    rd_next;

  // Bus decode. Subtracting the base lets the window test be one compare.
  assign offset    = address - BASE_ADDR;
  assign in_window = (offset < 8'd3);
  assign push      = write && (offset == 8'd0);
  assign ovf_clr   = write && (offset == 8'd1) && to_memory[3];

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  // A pop in the same edge frees the slot the push is about to fill.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  assign busy      = (state != IDLE) || !empty;
  assign state_dbg = state;
  assign baud_last = (baud == BAUD_MAX);

  // Read mux uses pre-edge status/count; the result is registered below.
  always_comb begin
    rd_next = 8'h00;
    if (in_window) begin
      case (offset)
        8'd1:    rd_next = {4'b0000, overflow, empty, full, busy};
        8'd2:    rd_next = 8'(count);
        default: rd_next = 8'h00;
      endcase
    end
  end

  // TX FSM next-state logic.
  always_comb begin
    state_next = state;
    baud_next  = baud + BW'(1);
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          bit_next   = 3'd0;
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next frame when data is waiting.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            bit_next   = 3'd0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase

    // tx is registered from the next state so it changes with the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      data_out <= 8'h00;
      hit      <= 1'b0;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
      data_out <= rd_next;
      hit      <= in_window;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set wins over a same-cycle clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= to_memory;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx (BASE_ADDR=8'hE0, CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Bytes expected on the line are queued when written; a line receiver
// checks every cycle of each 40-cycle frame against the queue head.

module tb_mmio_uart_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] to_memory = 8'h00;
  logic       write = 1'b0;
  logic [7:0] data_out;
  logic       hit;
  logic       tx;
  logic       busy;
  logic [1:0] state_dbg;

  mmio_uart_tx #(
    .BASE_ADDR   (8'hE0),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .to_memory(to_memory),
    .write    (write),
    .data_out (data_out),
    .hit      (hit),
    .tx       (tx),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Line receiver: sampled on the falling edge, one sample per cycle.
  logic       rx_hold = 1'b0;
  logic       rx_active = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_byte, rx_exp;
  logic       rx_shape_ok;
  logic       bit_exp;

  initial begin
    forever begin
      @(negedge clock);
      if (rx_hold) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && (tx === 1'b0)) begin
          rx_active   = 1'b1;
          rx_k        = 0;
          rx_byte     = 8'h00;
          rx_shape_ok = 1'b1;
          start_q.push_back(cyc);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          rx_exp = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        end
        if (rx_active) begin
          if (rx_k < 4)       bit_exp = 1'b0;
          else if (rx_k < 36) bit_exp = rx_exp[(rx_k - 4) / 4];
          else                bit_exp = 1'b1;
          if (tx !== bit_exp) rx_shape_ok = 1'b0;
          if (rx_k >= 4 && rx_k < 36 && ((rx_k - 4) % 4) == 2)
            rx_byte[(rx_k - 4) / 4] = tx;
          if (rx_k == 39) begin
            check("frame_data", rx_byte, rx_exp);
            check("frame_shape", rx_shape_ok, 1'b1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rx_active = 1'b0;
          end else begin
            rx_k++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic w);
    address   = a;
    to_memory = d;
    write     = w;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(8'h00, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    bus(8'hE0, d, 1'b1);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a,
                          input logic [7:0] exp, input logic exp_hit);
    bus(a, 8'h00, 1'b0);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_hit"}, hit, exp_hit);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || rx_active) && n < budget) begin
      idle(1);
      n++;
    end
    check({tag, "_drain"}, 32'(n < budget), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int n0;

  initial begin
    // Reset state
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_hit", hit, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    read_chk("rst_status", 8'hE1, 8'h04, 1'b1);
    read_chk("rst_count", 8'hE2, 8'h00, 1'b1);

    // Single byte: start bit launched by the edge after the write
    start_q.delete();
    send(8'hA5, 1'b1);
    n0 = cyc;
    idle(40);
    check("single_busy_stop", busy, 1'b1);
    idle(1);
    check("single_busy_done", busy, 1'b0);
    check("single_tx_idle", tx, 1'b1);
    check("single_start", (start_q.size() > 0) ? start_q[0] : -1, n0 + 1);
    check("single_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with no idle gap
    start_q.delete();
    send(8'h01, 1'b1);
    n0 = cyc;
    send(8'h80, 1'b1);
    send(8'hFF, 1'b1);
    read_chk("b2b_count", 8'hE2, 8'h02, 1'b1);
    wait_drain("b2b", 300);
    check("b2b_frames", start_q.size(), 3);
    check("b2b_start0", (start_q.size() > 0) ? start_q[0] : -1, n0 + 1);
    check("b2b_start1", (start_q.size() > 1) ? start_q[1] : -1, n0 + 41);
    check("b2b_start2", (start_q.size() > 2) ? start_q[2] : -1, n0 + 81);

    // Overflow, clear, then a push while full on the STOP->START pop edge
    start_q.delete();
    send(8'h11, 1'b1);
    n0 = cyc;
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    read_chk("ovf_status", 8'hE1, 8'h0B, 1'b1);
    bus(8'hE1, 8'h08, 1'b1);
    read_chk("ovf_clr_status", 8'hE1, 8'h03, 1'b1);
    idle(n0 + 40 - cyc);
    send(8'h77, 1'b1);
    check("fullpop_edge", cyc, n0 + 41);
    read_chk("fullpop_count", 8'hE2, 8'h04, 1'b1);
    read_chk("fullpop_status", 8'hE1, 8'h03, 1'b1);
    wait_drain("ovf", 600);
    check("ovf_frames", start_q.size(), 6);

    // Reset in the middle of a frame with more data queued
    send(8'hC3, 1'b1);
    send(8'h3C, 1'b1);
    idle(10);
    rx_hold = 1'b1;
    reset   = 1'b1;
    idle(2);
    reset = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    start_q.delete();
    rx_hold = 1'b0;
    read_chk("midrst_status", 8'hE1, 8'h04, 1'b1);
    read_chk("midrst_count", 8'hE2, 8'h00, 1'b1);
    idle(50);
    check("midrst_no_frame", start_q.size(), 0);
    check("midrst_tx_idle", tx, 1'b1);

    // Decode
    read_chk("dec_e3", 8'hE3, 8'h00, 1'b0);
    read_chk("dec_df", 8'hDF, 8'h00, 1'b0);
    bus(8'hE2, 8'hFF, 1'b1);
    read_chk("dec_count", 8'hE2, 8'h00, 1'b1);
    read_chk("dec_status", 8'hE1, 8'h04, 1'b1);
    check("dec_tx", tx, 1'b1);
    check("dec_busy", busy, 1'b0);
    read_chk("dec_txdata", 8'hE0, 8'h00, 1'b1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
